ex_mem_stage: RTL and testbench

- Pipeline boundary directly downstream of the ALU in the 16-bit WISC core.
- Captures ALU results into a single-entry EX/MEM register, using a valid/ready handshake with stall and flush.
- Owns the architectural N/Z/V flag register; flags update selectively per opcode.
- Evaluates the branch condition for B/BR instructions currently in EX.

---
 rtl/ex_mem_stage_if.sv | 40 ++++
 rtl/ex_mem_stage.sv | 113 +++++++++++
 tb/tb_ex_mem_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX-to-MEM handshake bundle: EX offers an ALU result, the stage holds it toward MEM.
// master drives the EX offer and MEM ready; slave is the stage itself.
interface ex_mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] ex_alu_out;
  logic              ex_error;
  logic              ex_n;
  logic              ex_z;
  logic              ex_v;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_store_data;
  logic [2:0]        ex_cc;

  logic              mem_valid;
  logic              mem_ready;
  logic [3:0]        mem_opcode;
  logic [DATA_W-1:0] mem_alu_out;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_store_data;
  logic              mem_error;

  modport master (
    output ex_valid, ex_opcode, ex_alu_out, ex_error, ex_n, ex_z, ex_v,
           ex_rd, ex_store_data, ex_cc, mem_ready,
    input  ex_ready, mem_valid, mem_opcode, mem_alu_out, mem_rd,
           mem_store_data, mem_error
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_alu_out, ex_error, ex_n, ex_z, ex_v,
           ex_rd, ex_store_data, ex_cc, mem_ready,
    output ex_ready, mem_valid, mem_opcode, mem_alu_out, mem_rd,
           mem_store_data, mem_error
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with N/Z/V flag ownership and branch evaluation; 1-cycle latency.
// Backpressure: ex_ready drops while a held entry is not consumed by MEM, and permanently after HLT.
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ex_mem_stage_if.slave bus,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_v,
  output logic          branch_taken,
  output logic          halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic              mem_valid_q;
  logic [3:0]        mem_opcode_q;
  logic [DATA_W-1:0] mem_alu_out_q;
  logic [REG_W-1:0]  mem_rd_q;
  logic [DATA_W-1:0] mem_store_data_q;
  logic              mem_error_q;
  logic              flag_n_q;
  logic              flag_z_q;
  logic              flag_v_q;
  logic              halted_q;

  logic ready;
  logic xfer;
  logic cond;
  logic is_branch;

  assign ready = !halted_q && (!mem_valid_q || bus.mem_ready);
  assign xfer  = bus.ex_valid && ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_opcode_q     <= '0;
      mem_alu_out_q    <= '0;
      mem_rd_q         <= '0;
      mem_store_data_q <= '0;
      mem_error_q      <= 1'b0;
      flag_n_q         <= 1'b0;
      flag_z_q         <= 1'b0;
      flag_v_q         <= 1'b0;
      halted_q         <= 1'b0;
    end else if (flush) begin
      // Data fields keep stale contents; only the valid bit is killed.
      mem_valid_q <= 1'b0;
    end else if (xfer) begin
      mem_valid_q      <= 1'b1;
      mem_opcode_q     <= bus.ex_opcode;
      mem_alu_out_q    <= bus.ex_alu_out;
      mem_rd_q         <= bus.ex_rd;
      mem_store_data_q <= bus.ex_store_data;
      mem_error_q      <= bus.ex_error;
      case (bus.ex_opcode)
        OP_ADD, OP_SUB: begin
          flag_n_q <= bus.ex_n;
          flag_z_q <= bus.ex_z;
          flag_v_q <= bus.ex_v;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_z_q <= bus.ex_z;
        OP_HLT: halted_q <= 1'b1;
        default: ;
      endcase
    end else if (!mem_valid_q || bus.mem_ready) begin
      mem_valid_q <= 1'b0;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (bus.ex_cc)
      3'b000:  cond = !flag_z_q;
      3'b001:  cond = flag_z_q;
      3'b010:  cond = !flag_z_q && !flag_n_q;
      3'b011:  cond = flag_n_q;
      3'b100:  cond = flag_z_q || (!flag_z_q && !flag_n_q);
      3'b101:  cond = flag_n_q || flag_z_q;
      3'b110:  cond = flag_v_q;
      default: cond = 1'b1;
    endcase
  end

  assign is_branch    = (bus.ex_opcode == OP_B) || (bus.ex_opcode == OP_BR);
  assign branch_taken = bus.ex_valid && is_branch && !halted_q && cond;

  assign bus.ex_ready       = ready;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_opcode     = mem_opcode_q;
  assign bus.mem_alu_out    = mem_alu_out_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_store_data = mem_store_data_q;
  assign bus.mem_error      = mem_error_q;
  assign flag_n             = flag_n_q;
  assign flag_z             = flag_z_q;
  assign flag_v             = flag_v_q;
  assign halted             = halted_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: hand-computed expectations checked with immediate assertions.
module tb_ex_mem_stage;
  logic clk;
  logic rst_n;
  logic flush;
  logic flag_n, flag_z, flag_v, branch_taken, halted;
  int   checks;
  int   errors;

  ex_mem_stage_if #(.DATA_W(16), .REG_W(4)) bus ();

  ex_mem_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .branch_taken (branch_taken),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [15:0] alu,
                       input logic n, input logic z, input logic v);
    bus.ex_valid   = 1'b1;
    bus.ex_opcode  = op;
    bus.ex_alu_out = alu;
    bus.ex_n       = n;
    bus.ex_z       = z;
    bus.ex_v       = v;
  endtask

  task automatic flags(input string tag, input logic n, input logic z, input logic v);
    check({tag, "_n"}, {31'd0, flag_n}, {31'd0, n});
    check({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
    check({tag, "_v"}, {31'd0, flag_v}, {31'd0, v});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_opcode = '0;
    bus.ex_alu_out = '0;
    bus.ex_error = 1'b0;
    bus.ex_n = 1'b0;
    bus.ex_z = 1'b0;
    bus.ex_v = 1'b0;
    bus.ex_rd = '0;
    bus.ex_store_data = '0;
    bus.ex_cc = '0;
    bus.mem_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_mem_alu", {16'd0, bus.mem_alu_out}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    flags("rst_flags", 1'b0, 1'b0, 1'b0);

    // ADD with N and V set
    offer(4'b0000, 16'h8000, 1'b1, 1'b0, 1'b1);
    bus.ex_rd = 4'd3;
    bus.ex_store_data = 16'hABCD;
    step();
    check("add_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
    check("add_mem_alu", {16'd0, bus.mem_alu_out}, 32'h8000);
    check("add_mem_rd", {28'd0, bus.mem_rd}, 32'd3);
    check("add_store", {16'd0, bus.mem_store_data}, 32'hABCD);
    flags("add_flags", 1'b1, 1'b0, 1'b1);

    // XOR touches Z only
    offer(4'b0010, 16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    check("xor_opcode", {28'd0, bus.mem_opcode}, 32'h2);
    flags("xor_flags", 1'b1, 1'b1, 1'b1);

    // LW leaves flags alone
    offer(4'b1000, 16'h0040, 1'b0, 1'b0, 1'b0);
    step();
    check("lw_mem_alu", {16'd0, bus.mem_alu_out}, 32'h0040);
    flags("lw_flags", 1'b1, 1'b1, 1'b1);

    // Stall three cycles with SUB offered
    bus.mem_ready = 1'b0;
    offer(4'b0001, 16'h1234, 1'b0, 1'b0, 1'b0);
    bus.ex_error = 1'b1;
    #1;
    check("stall_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      check("stall_mem_alu", {16'd0, bus.mem_alu_out}, 32'h0040);
      flags("stall_flags", 1'b1, 1'b1, 1'b1);
    end
    bus.mem_ready = 1'b1;
    #1;
    check("unstall_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    step();
    check("sub_mem_alu", {16'd0, bus.mem_alu_out}, 32'h1234);
    check("sub_opcode", {28'd0, bus.mem_opcode}, 32'h1);
    check("sub_error", {31'd0, bus.mem_error}, 32'd1);
    flags("sub_flags", 1'b0, 1'b0, 1'b0);
    bus.ex_error = 1'b0;

    // Branch evaluation with N=0 Z=0 V=0
    offer(4'b1101, 16'h0000, 1'b0, 1'b0, 1'b0);
    bus.ex_cc = 3'b010;
    #1;
    check("br_gt", {31'd0, branch_taken}, 32'd1);
    bus.ex_cc = 3'b011;
    #1;
    check("br_lt", {31'd0, branch_taken}, 32'd0);
    bus.ex_cc = 3'b001;
    #1;
    check("br_eq", {31'd0, branch_taken}, 32'd0);
    bus.ex_cc = 3'b100;
    #1;
    check("br_ge", {31'd0, branch_taken}, 32'd1);
    bus.ex_cc = 3'b111;
    #1;
    check("br_always", {31'd0, branch_taken}, 32'd1);
    bus.ex_opcode = 4'b1000;
    #1;
    check("br_not_branch", {31'd0, branch_taken}, 32'd0);
    bus.ex_opcode = 4'b1100;
    bus.ex_cc = 3'b010;
    bus.ex_valid = 1'b0;
    #1;
    check("br_invalid", {31'd0, branch_taken}, 32'd0);

    // Drain: no offer, MEM ready
    step();
    check("drain_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("drain_stale_alu", {16'd0, bus.mem_alu_out}, 32'h1234);

    // Flush while an entry is held and ADD is offered
    offer(4'b1000, 16'h0055, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_flush_valid", {31'd0, bus.mem_valid}, 32'd1);
    bus.mem_ready = 1'b0;
    offer(4'b0000, 16'h7777, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("flush_mem_alu", {16'd0, bus.mem_alu_out}, 32'h0055);
    flags("flush_flags", 1'b0, 1'b0, 1'b0);

    // ADD sets all flags, then HLT
    bus.mem_ready = 1'b1;
    offer(4'b0000, 16'h0000, 1'b1, 1'b1, 1'b1);
    step();
    flags("add2_flags", 1'b1, 1'b1, 1'b1);
    offer(4'b1111, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step();
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_opcode", {28'd0, bus.mem_opcode}, 32'hF);
    check("hlt_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
    check("hlt_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
    offer(4'b1101, 16'h0000, 1'b0, 1'b0, 1'b0);
    bus.ex_cc = 3'b111;
    #1;
    check("hlt_branch", {31'd0, branch_taken}, 32'd0);
    offer(4'b0000, 16'h9999, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("hlt_no_capture_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("hlt_no_capture_alu", {16'd0, bus.mem_alu_out}, 32'hFFFF);
    flags("hlt_flags", 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_keeps_halt", {31'd0, halted}, 32'd1);

    // Reset out of halt
    bus.ex_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_halted", {31'd0, halted}, 32'd0);
    check("post_rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("post_rst_opcode", {28'd0, bus.mem_opcode}, 32'd0);
    check("post_rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    flags("post_rst_flags", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
